// File: rtl/axis_frame_gen_if.sv
// axis_frame_gen_if: length-command handshake plus AXI stream master bus of
// the frame generator.
//   s_len/s_len_valid/s_len_ready : frame length command (valid/ready)
//   m_axis_t*                     : generated AXI stream
// With AXIS_FRAME_GEN_TUSER_EN defined, two more signals are added:
//   s_len_err    : error flag that travels with the command
//   m_axis_tuser : that flag, shown on the last beat of the frame
// Modports: master = generator side, slave = command source / stream sink.
interface axis_frame_gen_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16
);
  logic [LEN_WIDTH-1:0]  s_len;
  logic                  s_len_valid;
  logic                  s_len_ready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [KEEP_WIDTH-1:0] m_axis_tkeep;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
`ifdef AXIS_FRAME_GEN_TUSER_EN
  logic                  s_len_err;
  logic                  m_axis_tuser;
`endif

  modport master (
    input  s_len, s_len_valid, m_axis_tready,
    output s_len_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
`ifdef AXIS_FRAME_GEN_TUSER_EN
    , input s_len_err, output m_axis_tuser
`endif
  );

  modport slave (
    output s_len, s_len_valid, m_axis_tready,
    input  s_len_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
`ifdef AXIS_FRAME_GEN_TUSER_EN
    , output s_len_err, input m_axis_tuser
`endif
  );
endinterface

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: takes a frame length command and emits one AXI stream
// frame of exactly that length with a byte-index payload
// (lane k = (byte_index + k) mod 256).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : axis_frame_gen_if.master (length command in, stream out)
//   busy     : high while a frame is being sent
// Length is in bytes when KEEP_ENABLE=1, in beats when KEEP_ENABLE=0.
// Optional feature macro: AXIS_FRAME_GEN_TUSER_EN. It adds s_len_err and
// m_axis_tuser, and the flag captured with the command is shown on the last
// beat of the frame.
module axis_frame_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst,
  axis_frame_gen_if.master  bus,
  output logic              busy
);
  typedef enum logic {IDLE, TRANSFER} state_t;

  // Remaining count drops by one beat's worth per accepted beat.
  localparam logic [LEN_WIDTH-1:0] STEP = KEEP_ENABLE ? LEN_WIDTH'(KEEP_WIDTH) : LEN_WIDTH'(1);
  localparam logic [7:0]           IDX_STEP = 8'(KEEP_WIDTH);

  state_t                state_q, state_n;
  logic [LEN_WIDTH-1:0]  rem_q, rem_n;   // units still to send, including the beat on the bus
  logic [7:0]            idx_q, idx_n;   // byte index of lane 0, kept mod 256
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [KEEP_WIDTH-1:0] keep_q, keep_n;
  logic                  last_q, last_n;
`ifdef AXIS_FRAME_GEN_TUSER_EN
  logic                  err_q, err_n;
  logic                  user_q, user_n;
`endif

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [7:0] base);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) d[k*8 +: 8] = base + 8'(k);
    return d;
  endfunction

  // The beat carrying rem units is the last one when it holds all of them.
  function automatic logic is_last(input logic [LEN_WIDTH-1:0] r);
    if (KEEP_ENABLE) return 32'(r) <= 32'(KEEP_WIDTH);
    else             return r == LEN_WIDTH'(1);
  endfunction

  // The last beat keeps only the low r lanes. Since r is in 1..KEEP_WIDTH,
  // r == KEEP_WIDTH gives all ones without a special case.
  function automatic logic [KEEP_WIDTH-1:0] keep_for(input logic [LEN_WIDTH-1:0] r);
    logic [KEEP_WIDTH-1:0] kp;
    kp = '1;
    if (KEEP_ENABLE && is_last(r))
      for (int k = 0; k < KEEP_WIDTH; k++) kp[k] = 32'(k) < 32'(r);
    return kp;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
`ifdef AXIS_FRAME_GEN_TUSER_EN
      err_q  <= 1'b0;
      user_q <= 1'b0;
`endif
    end else begin
      rem_q  <= rem_n;
      idx_q  <= idx_n;
      data_q <= data_n;
      keep_q <= keep_n;
      last_q <= last_n;
`ifdef AXIS_FRAME_GEN_TUSER_EN
      err_q  <= err_n;
      user_q <= user_n;
`endif
    end
  end

  // Next-state and next-beat logic. A new beat is loaded whenever a
  // command is accepted or the current beat is taken, so every output
  // comes straight from a register and holds while stalled.
  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    idx_n   = idx_q;
    data_n  = data_q;
    keep_n  = keep_q;
    last_n  = last_q;
`ifdef AXIS_FRAME_GEN_TUSER_EN
    err_n   = err_q;
    user_n  = user_q;
`endif
    case (state_q)
      IDLE: begin
        // A zero-length command is consumed here and nothing else happens.
        if (bus.s_len_valid && bus.s_len != '0) begin
          state_n = TRANSFER;
          rem_n   = bus.s_len;
          idx_n   = '0;
          data_n  = pattern(8'd0);
          keep_n  = keep_for(bus.s_len);
          last_n  = is_last(bus.s_len);
`ifdef AXIS_FRAME_GEN_TUSER_EN
          err_n   = bus.s_len_err;
          user_n  = bus.s_len_err & is_last(bus.s_len);
`endif
        end
      end
      TRANSFER: begin
        if (bus.m_axis_tready) begin
          if (last_q) begin
            state_n = IDLE;
            last_n  = 1'b0;
`ifdef AXIS_FRAME_GEN_TUSER_EN
            user_n  = 1'b0;
`endif
          end else begin
            rem_n  = rem_q - STEP;
            idx_n  = idx_q + IDX_STEP;
            data_n = pattern(idx_n);
            keep_n = keep_for(rem_n);
            last_n = is_last(rem_n);
`ifdef AXIS_FRAME_GEN_TUSER_EN
            user_n = err_q & is_last(rem_n);
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy              = (state_q == TRANSFER);
  assign bus.s_len_ready   = (state_q == IDLE);
  assign bus.m_axis_tvalid = (state_q == TRANSFER);
  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tkeep  = keep_q;
  assign bus.m_axis_tlast  = last_q;
`ifdef AXIS_FRAME_GEN_TUSER_EN
  assign bus.m_axis_tuser  = user_q;
`endif
endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  axis_frame_gen_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW)) bus ();

  axis_frame_gen #(.DATA_WIDTH(DW), .KEEP_ENABLE(1'b1), .KEEP_WIDTH(KW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [63:0] cap_data[$];
  logic [7:0]  cap_keep[$];
  logic        cap_last[$];
  logic        cap_user[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_data(input int b);
    logic [63:0] d;
    for (int k = 0; k < KW; k++) d[k*8 +: 8] = 8'((b * KW + k) % 256);
    return d;
  endfunction

  function automatic logic [7:0] exp_keep(input int len, input int b);
    int nb = (len + KW - 1) / KW;
    if (b == nb - 1 && (len % KW) != 0) return 8'((1 << (len % KW)) - 1);
    return 8'hFF;
  endfunction

  // Called at posedge+1; the command is taken at the next edge.
  task automatic send(input int len, input logic err);
    chk("cmd ready", bus.s_len_ready, 1);
    bus.s_len       = LW'(len);
    bus.s_len_valid = 1'b1;
`ifdef AXIS_FRAME_GEN_TUSER_EN
    bus.s_len_err   = err;
`else
    if (err) $display("note: error flag ignored in this build");
`endif
    @(posedge clk); #1;
    bus.s_len_valid = 1'b0;
  endtask

  // Receives one frame, checking every valid cycle (stalls included) against the model.
  task automatic collect(input string tag, input int len, input bit rnd, input logic err);
    int nb = (len + KW - 1) / KW;
    int n = 0;
    int cyc = 0;
    bit done = 0;
    logic v, l, u;
    logic [63:0] d;
    logic [7:0] kp;
    cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_user.delete();
    while (!done && cyc < 4000) begin
      bus.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      v  = bus.m_axis_tvalid;
      d  = bus.m_axis_tdata;
      kp = bus.m_axis_tkeep;
      l  = bus.m_axis_tlast;
      u  = 1'b0;
`ifdef AXIS_FRAME_GEN_TUSER_EN
      u  = bus.m_axis_tuser;
`endif
      if (v) begin
        chk({tag, " data"}, d, exp_data(n));
        chk({tag, " keep"}, 64'(kp), 64'(exp_keep(len, n)));
        chk({tag, " last"}, 64'(l), 64'(n == nb - 1));
`ifdef AXIS_FRAME_GEN_TUSER_EN
        chk({tag, " user"}, 64'(u), 64'((n == nb - 1) && err));
`endif
      end
      @(posedge clk); #1;
      cyc++;
      if (v && bus.m_axis_tready) begin
        cap_data.push_back(d); cap_keep.push_back(kp);
        cap_last.push_back(l); cap_user.push_back(u);
        n++;
        if (l) done = 1;
      end
    end
    bus.m_axis_tready = 1'b0;
    chk({tag, " finished"}, 64'(done), 1);
    chk({tag, " beats"}, 64'(n), 64'(nb));
  endtask

  initial begin
    int bytes;
    rst = 1'b1;
    bus.s_len = '0;
    bus.s_len_valid = 1'b0;
    bus.m_axis_tready = 1'b0;
`ifdef AXIS_FRAME_GEN_TUSER_EN
    bus.s_len_err = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", bus.s_len_ready, 1);
    chk("rst tvalid", bus.m_axis_tvalid, 0);
    chk("rst tlast", bus.m_axis_tlast, 0);
    chk("rst tdata", bus.m_axis_tdata, 0);
    chk("rst tkeep", 64'(bus.m_axis_tkeep), 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // len=16, tready high
    send(16, 1'b0);
    chk("len16 busy", busy, 1);
    chk("len16 ready low", bus.s_len_ready, 0);
    collect("len16", 16, 0, 1'b0);
    if (cap_data.size() == 2) begin
      chk("len16 b0 data", cap_data[0], 64'h0706050403020100);
      chk("len16 b0 keep", 64'(cap_keep[0]), 64'hFF);
      chk("len16 b0 last", 64'(cap_last[0]), 0);
      chk("len16 b1 data", cap_data[1], 64'h0F0E0D0C0B0A0908);
      chk("len16 b1 keep", 64'(cap_keep[1]), 64'hFF);
      chk("len16 b1 last", 64'(cap_last[1]), 1);
    end
    chk("len16 dead ready", bus.s_len_ready, 1);
    chk("len16 dead tvalid", bus.m_axis_tvalid, 0);

    // len=13, with a command offered mid-frame that must be ignored
    send(13, 1'b0);
    bus.s_len = LW'(3);
    bus.s_len_valid = 1'b1;
    @(posedge clk); #1;
    bus.s_len_valid = 1'b0;
    collect("len13", 13, 0, 1'b0);
    bytes = 0;
    foreach (cap_keep[i]) bytes += $countones(cap_keep[i]);
    chk("len13 bytes", 64'(bytes), 13);
    if (cap_keep.size() == 2) chk("len13 b1 keep", 64'(cap_keep[1]), 64'h1F);
    repeat (3) @(posedge clk);
    #1;
    chk("len13 no extra frame", bus.m_axis_tvalid, 0);

    // zero-length commands, then len=1
    send(0, 1'b0);
    chk("len0 tvalid", bus.m_axis_tvalid, 0);
    chk("len0 busy", busy, 0);
    send(0, 1'b0);
    chk("len0 second tvalid", bus.m_axis_tvalid, 0);
    send(1, 1'b0);
    collect("len1", 1, 0, 1'b0);
    if (cap_data.size() == 1) begin
      chk("len1 lane0", 64'(cap_data[0][7:0]), 0);
      chk("len1 keep", 64'(cap_keep[0]), 64'h01);
      chk("len1 last", 64'(cap_last[0]), 1);
    end

    // len=300, random backpressure
    send(300, 1'b0);
    collect("len300", 300, 1, 1'b0);
    if (cap_data.size() == 38) begin
      chk("len300 b32 data", cap_data[32], 64'h0706050403020100);
      chk("len300 last keep", 64'(cap_keep[37]), 64'h0F);
    end

    // reset during beat 3 of len=64
    send(64, 1'b0);
    bus.m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("len64 b2 data", bus.m_axis_tdata, 64'h1716151413121110);
    bus.m_axis_tready = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst tvalid", bus.m_axis_tvalid, 0);
    chk("midrst ready", bus.s_len_ready, 1);
    chk("midrst tlast", bus.m_axis_tlast, 0);
    chk("midrst tdata", bus.m_axis_tdata, 0);
    chk("midrst busy", busy, 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8, 1'b0);
    collect("len8", 8, 0, 1'b0);
    if (cap_data.size() == 1) begin
      chk("len8 data", cap_data[0], 64'h0706050403020100);
      chk("len8 keep", 64'(cap_keep[0]), 64'hFF);
    end

`ifdef AXIS_FRAME_GEN_TUSER_EN
    send(24, 1'b1);
    collect("user1", 24, 0, 1'b1);
    if (cap_user.size() == 3) begin
      chk("user1 b0", 64'(cap_user[0]), 0);
      chk("user1 b1", 64'(cap_user[1]), 0);
      chk("user1 b2", 64'(cap_user[2]), 1);
    end
    send(24, 1'b0);
    collect("user0", 24, 0, 1'b0);
    if (cap_user.size() == 3) chk("user0 b2", 64'(cap_user[2]), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
